// File: rtl/mem_arbiter.sv
// Arbiter and sequencer sharing one fixed-latency, single-port memory between a
// read-only fetch port and a read/write load/store port.
module mem_arbiter #(
    parameter int WAIT_CYCLES = 6,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_ack,
    output logic [DATA_W-1:0] ls_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_load,
    output logic              mem_store,
    inout  wire  [DATA_W-1:0] mem_data,
    output logic              busy
);
    localparam int               CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_ls_q, last_ls_d;
    logic              gnt_ls_q, gnt_ls_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
    logic              pick_ls;

    // On a tie the port that did not win last time is served.
    assign pick_ls = ls_req && (!if_req || !last_ls_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_ls_d  = last_ls_q;
        gnt_ls_d   = gnt_ls_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (if_req || ls_req) begin
                    gnt_ls_d  = pick_ls;
                    last_ls_d = pick_ls;
                    addr_d    = pick_ls ? ls_addr : if_addr;
                    we_d      = pick_ls && ls_we;
                    wdata_d   = ls_wdata;
                    cnt_d     = CNT_LOAD;
                    state_d   = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    if (!we_q) begin
                        if (gnt_ls_q) begin
                            ls_rdata_d = mem_data;
                        end else begin
                            if_rdata_d = mem_data;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            last_ls_q  <= 1'b0;
            gnt_ls_q   <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_ls_q  <= last_ls_d;
            gnt_ls_q   <= gnt_ls_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    // Strobes decode straight from reset-cleared registers so reset drops them at once.
    assign busy      = (state_q != S_IDLE);
    assign mem_addr  = addr_q;
    assign mem_load  = (state_q == S_ACCESS) && !we_q;
    assign mem_store = (state_q == S_ACCESS) && we_q && (cnt_q == CNT_LOAD);
    assign if_ack    = (state_q == S_DONE) && !gnt_ls_q;
    assign ls_ack    = (state_q == S_DONE) && gnt_ls_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;
    assign mem_data  = (we_q && busy) ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level schedule model checks every cycle,
// plus literal latency/data expectations and a separate WAIT_CYCLES=1 instance.
module tb_mem_arbiter;
    localparam int          W    = 6;
    localparam logic [15:0] SENT = 16'h5A5A;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        if_req, if_ack, ls_req, ls_we, ls_ack, mem_load, mem_store, busy;
    logic [15:0] if_addr, if_rdata, ls_addr, ls_wdata, ls_rdata, mem_addr;
    wire  [15:0] mem_data;

    logic        r1_req, r1_we, r1_ack, r1_if_ack, r1_mem_load, r1_mem_store, r1_busy;
    logic [15:0] r1_addr, r1_wdata, r1_rdata, r1_if_rdata, r1_mem_addr;
    wire  [15:0] r1_mem_data;

    logic [15:0] mem [256];
    logic [15:0] ref_mem [256];
    logic [15:0] mem1 [256];

    mem_arbiter #(.WAIT_CYCLES(W), .ADDR_W(16), .DATA_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ack(ls_ack), .ls_rdata(ls_rdata),
        .mem_addr(mem_addr), .mem_load(mem_load), .mem_store(mem_store),
        .mem_data(mem_data), .busy(busy)
    );

    mem_arbiter #(.WAIT_CYCLES(1), .ADDR_W(16), .DATA_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(1'b0), .if_addr(16'h0000), .if_ack(r1_if_ack), .if_rdata(r1_if_rdata),
        .ls_req(r1_req), .ls_we(r1_we), .ls_addr(r1_addr), .ls_wdata(r1_wdata),
        .ls_ack(r1_ack), .ls_rdata(r1_rdata),
        .mem_addr(r1_mem_addr), .mem_load(r1_mem_load), .mem_store(r1_mem_store),
        .mem_data(r1_mem_data), .busy(r1_busy)
    );

    // Memory device; while the arbiter is idle the bench parks a sentinel on the bus,
    // so any arbiter drive in an idle cycle corrupts it.
    assign mem_data    = mem_load ? mem[mem_addr[7:0]] : (busy ? 16'hzzzz : SENT);
    assign r1_mem_data = r1_mem_load ? mem1[r1_mem_addr[7:0]] : 16'hzzzz;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        total++;
        if (act_v === exp_v) passed++;
        else $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act_v, exp_v);
    endtask

    // Model: one access occupies a window [st+1, st+W+1] after the grant cycle st.
    bit          act, was_act, last_ls, g_ls, g_we;
    int          st;
    logic [15:0] g_addr, g_wd, e_ifr, e_lsr, e_addr;
    logic        e_busy, e_load, e_store, e_ifa, e_lsa;
    bit          grant_log[$];

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = '0; ref_mem[i] = '0; mem1[i] = '0;
        end
        mem[0] = 16'hF101; mem[1] = 16'hF210; mem[2] = 16'h4001;
        ref_mem[0] = 16'hF101; ref_mem[1] = 16'hF210; ref_mem[2] = 16'h4001;
        act = 0; last_ls = 0; e_ifr = '0; e_lsr = '0; e_addr = '0; st = 0;
        g_ls = 0; g_we = 0; g_addr = '0; g_wd = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                act = 0; last_ls = 0; e_ifr = '0; e_lsr = '0; e_addr = '0;
            end
            e_busy = 0; e_load = 0; e_store = 0; e_ifa = 0; e_lsa = 0;
            if (act) begin
                if (cyc == st + 1) e_addr = g_addr;
                e_busy  = 1;
                e_load  = !g_we && (cyc <= st + W);
                e_store = g_we && (cyc == st + 1);
                if (cyc == st + W + 1) begin
                    if (g_ls) e_lsa = 1; else e_ifa = 1;
                    if (!g_we) begin
                        if (g_ls) e_lsr = ref_mem[g_addr[7:0]];
                        else      e_ifr = ref_mem[g_addr[7:0]];
                    end
                end
            end
            chk("busy", busy, e_busy);
            chk("mem_load", mem_load, e_load);
            chk("mem_store", mem_store, e_store);
            chk("if_ack", if_ack, e_ifa);
            chk("ls_ack", ls_ack, e_lsa);
            chk("if_rdata", if_rdata, e_ifr);
            chk("ls_rdata", ls_rdata, e_lsr);
            chk("mem_addr", mem_addr, e_addr);
            if (!e_busy)   chk("bus_idle_z", mem_data, SENT);
            else if (g_we) chk("bus_wdata", mem_data, g_wd);
            if (mem_store)    mem[mem_addr[7:0]] = mem_data;
            if (r1_mem_store) mem1[r1_mem_addr[7:0]] = r1_mem_data;
            was_act = act;
            if (act && cyc == st + W + 1) act = 0;
            if (rst_n && !was_act && (if_req || ls_req)) begin
                g_ls    = ls_req && (!if_req || !last_ls);
                last_ls = g_ls;
                g_addr  = g_ls ? ls_addr : if_addr;
                g_we    = g_ls && ls_we;
                g_wd    = ls_wdata;
                if (g_we) ref_mem[g_addr[7:0]] = g_wd;
                st  = cyc;
                act = 1;
                grant_log.push_back(g_ls);
            end
        end
    end

    // mode 0: hold inputs; 1: scramble inputs after grant; 2: also drop req before ack.
    task automatic req_do(input bit ls, input bit we, input logic [15:0] a, input logic [15:0] d,
                          input int mode, output int lat, output logic [15:0] rd,
                          output int n_st, output int n_dr);
        int n;
        bit seen;
        @(posedge clk); #1;
        if (ls) begin ls_we = we; ls_addr = a; ls_wdata = d; ls_req = 1; end
        else begin if_addr = a; if_req = 1; end
        n = 0; seen = 0; n_st = 0; n_dr = 0; lat = -1; rd = '0;
        while (!seen && n < 40) begin
            @(negedge clk); #1;
            n++;
            if (mem_store) n_st++;
            if (busy && mem_data === d) n_dr++;
            if (n == 2 && mode != 0) begin
                if (ls) begin
                    ls_addr = ~a; ls_wdata = ~d; ls_we = ~we;
                    if (mode == 2) ls_req = 0;
                end else begin
                    if_addr = ~a;
                    if (mode == 2) if_req = 0;
                end
            end
            if (ls ? ls_ack : if_ack) begin
                seen = 1; lat = n; rd = ls ? ls_rdata : if_rdata;
            end
        end
        if (!seen) chk(ls ? "ls_ack_timeout" : "if_ack_timeout", 0, 1);
        @(posedge clk); #1;
        if (ls) ls_req = 0; else if_req = 0;
    endtask

    task automatic d1_do(input bit we, input logic [15:0] a, input logic [15:0] d,
                         output int lat, output logic [15:0] rd);
        int n;
        bit seen;
        @(posedge clk); #1;
        r1_we = we; r1_addr = a; r1_wdata = d; r1_req = 1;
        n = 0; seen = 0; lat = -1; rd = '0;
        while (!seen && n < 20) begin
            @(negedge clk); #1;
            n++;
            if (r1_ack) begin
                seen = 1; lat = n; rd = r1_rdata;
                chk("w1_mem_addr", r1_mem_addr, a);
            end
        end
        if (!seen) chk("w1_ack_timeout", 0, 1);
        @(posedge clk); #1;
        r1_req = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    initial begin
        int          lat, lat2, ns, nd, ns2, nd2;
        logic [15:0] rd, rd2;
        logic [5:0]  pat;
        rst_n = 0; if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0;
        r1_req = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        req_do(0, 0, 16'h0000, 16'h0000, 0, lat, rd, ns, nd);
        chk("if_read_latency", lat, 8);
        chk("if_read_data", rd, 16'hF101);

        req_do(1, 1, 16'h0040, 16'hBEEF, 1, lat, rd, ns, nd);
        chk("store_latency", lat, 8);
        chk("store_pulses", ns, 1);
        chk("store_drive_cycles", nd, 7);
        req_do(1, 0, 16'h0040, 16'h0000, 0, lat, rd, ns, nd);
        chk("load_back_data", rd, 16'hBEEF);

        do_reset();
        fork
            req_do(1, 0, 16'h0002, 16'h0000, 0, lat, rd, ns, nd);
            req_do(0, 0, 16'h0001, 16'h0000, 0, lat2, rd2, ns2, nd2);
        join
        chk("tie_ls_latency", lat, 8);
        chk("tie_ack_gap", lat2 - lat, 8);
        chk("tie_ls_data", rd, 16'h4001);
        chk("tie_if_data", rd2, 16'hF210);

        grant_log.delete();
        fork
            for (int k = 0; k < 3; k++) req_do(1, 0, 16'h0002, 16'h0000, 0, lat, rd, ns, nd);
            for (int k = 0; k < 3; k++) req_do(0, 0, 16'h0000, 16'h0000, 0, lat2, rd2, ns2, nd2);
        join
        chk("rr_grant_count", grant_log.size(), 6);
        pat = '0;
        for (int i = 0; i < 6 && i < grant_log.size(); i++) pat[5-i] = grant_log[i];
        chk("rr_grant_order", pat, 6'b101010);

        req_do(1, 0, 16'h0001, 16'h0000, 2, lat, rd, ns, nd);
        chk("early_drop_latency", lat, 8);
        chk("early_drop_data", rd, 16'hF210);

        @(posedge clk); #1;
        if_addr = 16'h0001; if_req = 1;
        repeat (3) @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("rst_mem_load", mem_load, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bus_z", mem_data, SENT);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        if_req = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        req_do(0, 0, 16'h0002, 16'h0000, 0, lat, rd, ns, nd);
        chk("post_rst_latency", lat, 8);
        chk("post_rst_data", rd, 16'h4001);

        d1_do(1, 16'hFFFF, 16'h1234, lat, rd);
        chk("w1_store_latency", lat, 3);
        d1_do(0, 16'hFFFF, 16'h0000, lat, rd);
        chk("w1_load_latency", lat, 3);
        chk("w1_load_data", rd, 16'h1234);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port 16-bit unified memory (load/store strobes, bidirectional data bus, fixed access latency).
- Shares the memory between the instruction-fetch port (read-only) and the load/store port (read/write).
- Holds address, strobes and write data stable for the full memory latency, captures read data, and returns a one-cycle acknowledge to the granted requester.

Parameters:
- WAIT_CYCLES, 6, clock cycles the memory needs per access (ceil(memory time / clock period)); legal range 1..15.
- ADDR_W, 16, address width.
- DATA_W, 16, data width.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- if_req  input  1  fetch request, level, held until if_ack
- if_addr  input  ADDR_W  fetch address, stable while if_req
- if_ack  output  1  one-cycle pulse, fetch complete
- if_rdata  output  DATA_W  fetched word, valid in if_ack cycle, held until next fetch ack
- ls_req  input  1  load/store request, level, held until ls_ack
- ls_we  input  1  1 = store, 0 = load; stable while ls_req
- ls_addr  input  ADDR_W  load/store address
- ls_wdata  input  DATA_W  store data
- ls_ack  output  1  one-cycle pulse, load/store complete
- ls_rdata  output  DATA_W  loaded word, valid in ls_ack cycle, held until next load ack
- mem_addr  output  ADDR_W  memory address
- mem_load  output  1  memory read enable
- mem_store  output  1  memory write strobe
- mem_data  inout  DATA_W  memory data bus
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, counter=0, last_grant=IF. All outputs 0: if_ack, ls_ack, if_rdata, ls_rdata, mem_addr, mem_load, mem_store, busy. mem_data is high-Z.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - Any request present: latch grant (IF or LS), address, we and wdata into registers; next state ACCESS; counter=WAIT_CYCLES-1.
  - Arbitration: one requester wins alone. On a tie, round-robin: the winner is the port not equal to last_grant. Reset value makes LS win the first tie.
  - last_grant updates at grant time.
- ACCESS:
  - mem_addr = latched address.
  - Read: mem_load=1 for every ACCESS cycle.
  - Write: mem_store=1 only in the first ACCESS cycle, giving exactly one memory write trigger. mem_data is driven with latched wdata for all ACCESS and DONE cycles. Otherwise mem_data is high-Z.
  - Counter decrements each cycle. When the counter is 0, next state is DONE. Read data is sampled from mem_data on that edge into the granted port's rdata register.
  - ACCESS therefore lasts exactly WAIT_CYCLES cycles.
- DONE:
  - Granted port's ack=1 for exactly one cycle.
  - mem_load=0, mem_store=0. mem_addr holds its value.
  - Next state IDLE.
  - Requester drops req on the edge after ack.
- IDLE is mandatory between accesses. It provides the bus turnaround and consumes the dropped request.
- Latency:
  - Request seen in IDLE → ack at cycle 1+WAIT_CYCLES+1 (8 cycles at default).
  - Back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
- Boundary cases:
  - Requests arriving during ACCESS/DONE wait. The arbiter never preempts.
  - ls_addr, ls_we, ls_wdata and if_addr changes after grant are ignored (latched).
  - A requester dropping req before ack: the access still completes, and the ack is still pulsed.
  - Address 16'hFFFF is a legal address with no wrap special-case.
  - rst_n asserted mid-ACCESS: immediate return to reset values. mem_store/mem_load drop and mem_data releases asynchronously. The interrupted write may or may not land; no ack is issued.
  - Both ack outputs are never high in the same cycle.
  - mem_load and mem_store are never high in the same cycle.

Test Plan:
- Reset then IF read: memory preloaded mem[0]=16'hF101; if_req=1, if_addr=0 → mem_load high 6 cycles, if_ack pulse in cycle 8, if_rdata=16'hF101, ls_ack stays 0.
- LS store then load: store ls_addr=16'h0040, ls_wdata=16'hBEEF → mem_store is a single one-cycle pulse and mem_data is driven 7 cycles. Follow-up load of 16'h0040 → ls_rdata=16'hBEEF.
- Simultaneous requests after reset: if_req=ls_req=1 (load from 2 and fetch from 1) → LS served first; IF served next. The acks are separated by 8 cycles and returned data matches mem[2]=16'h4001 and mem[1]=16'hF210.
- Sustained contention: both ports hold requests for 6 accesses → grants alternate LS,IF,LS,IF,LS,IF; no starvation; mem_data high-Z in every IDLE cycle.
- Mid-access reset: assert rst_n low in the 3rd ACCESS cycle of a load → all outputs 0 and mem_data high-Z within the same cycle; no ack; the next request after reset completes normally in 8 cycles.
- WAIT_CYCLES=1 build: single LS store to 16'hFFFF followed by a load → each ack arrives 3 cycles after the request; read returns the written value.
